noc_egress_port: RTL and testbench
==================================

# noc_egress_port

Egress end of the mini-AIE NoC ring: accepts words that the final switch writes out of the ring, buffers them, and hands them to an off-chip host one word at a time over a 4-phase req/ack handshake on the bidirectional pins. It is the counterpart of the ingress FIFO, which takes host words in every enabled cycle with no handshake. It sits between the last switch's `switch_fifo_out`/`wr_en` pair and `uo_out`/`uio`.

## Interface
Parameters:
- `DEPTH`, 4: buffer entries; must be a power of two, ≥2.
- `DATA_WIDTH`, 8: word width.

Ports:
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `ena` input 1: design enable; when low, the block is frozen.
- `noc_data_in` input DATA_WIDTH: word from the last switch.
- `noc_wr_en` input 1: write strobe from the last switch; one word per cycle while high.
- `noc_full` output 1: buffer full; tells the switch to hold.
- `host_ack` input 1: host acknowledge from the pin; asynchronous to `clk`.
- `host_data` output DATA_WIDTH: word presented to the host (registered).
- `host_req` output 1: word valid on `host_data` (registered).
- `level` output $clog2(DEPTH)+1: number of buffered words, not counting the word on `host_data`.
- `drop_count` output 8: count of words lost to overflow; saturates at 255.

## Operation
- **Reset** (`rst_n`=0 at an edge):
  - Pointers and `level` go to 0.
  - FSM goes to IDLE.
  - `host_req`=0, `host_data`=0, `drop_count`=0.
  - Both synchronizer flops go to 0.
  - Reset mid-handshake abandons the word on `host_data` and all buffered words.
- **Synchronizer**: `host_ack` passes through two flops to give `ack_s`. The flops run even when `ena`=0 and are cleared by reset.
- **Push**:
  - Condition: `ena` & `noc_wr_en` & !`noc_full`.
  - Action: write `noc_data_in` at the write pointer; the pointer wraps modulo DEPTH.
- **Overflow**:
  - Condition: `ena` & `noc_wr_en` & `noc_full`.
  - The word is discarded; `drop_count` increments, saturating at 255.
  - Push is refused when full even if a pop happens in the same cycle. `noc_full` is purely `level`==DEPTH.
- **Pop**: happens only as the IDLE→REQ transition, and reads the word at the read pointer.
- **Simultaneous push and pop** (not full): both happen; `level` is unchanged.
- **FSM** (advances only when `ena`=1):
  - IDLE, `level`>0: `host_data` ← head, pop, `host_req` ← 1, go to REQ.
  - IDLE, `level`=0: stay.
  - REQ, `ack_s`=1: `host_req` ← 0, go to RELEASE.
  - REQ, `ack_s`=0: stay; `host_data` is held stable.
  - RELEASE, `ack_s`=0: go to IDLE.
  - RELEASE, `ack_s`=1: stay.
  - `host_data` keeps the last popped word until the next pop.
- **`ena`=0**: no push, no pop, no drop counting, FSM holds, all outputs hold.
- A word written while `level`=0 and FSM=IDLE is still stored in the buffer first; there is no bypass path.

## Timing
- Cycle numbering: "cycle n" is the period before edge n+1.
- **Ingress to req**: `noc_wr_en`=1 in cycle 0 with the FSM in IDLE and the buffer empty gives `host_req`=1 and valid `host_data` from cycle 2.
- **Ack to req drop**: `host_ack` rising in cycle k gives `ack_s`=1 in cycle k+2 and `host_req`=0 from cycle k+3.
- **Ack release**: `host_ack` falling in cycle m gives RELEASE→IDLE at the end of cycle m+2. If `level`>0, the next `host_req` rises in cycle m+4.
- **`noc_full` and `level`** update one edge after the push or pop that changes them.
- **Throughput** is bounded by the host handshake. The buffer absorbs bursts of up to DEPTH words, plus one word held on `host_data`.

## Test plan
- **Reset values**: drive `rst_n`=0 for 2 cycles with `noc_wr_en`=1 → `host_req`=0, `host_data`=0x00, `level`=0, `drop_count`=0, `noc_full`=0.
- **Single word**: push 0xA5 in cycle 0 → `host_req`=1 with `host_data`=0xA5 in cycle 2. Raise `host_ack` in cycle 5 → `host_req`=0 in cycle 8. Drop `host_ack` → FSM returns to IDLE, `level`=0.
- **Burst ordering**:
  - Setup: host holds `host_ack`=0; push 0x01..0x05 in consecutive cycles.
  - Required: 0x01 appears on `host_data` first; `level` reaches 4; `noc_full`=1.
  - Then run 5 handshakes: the host receives 0x01, 0x02, 0x03, 0x04, 0x05 in order, and `drop_count`=0.
- **Overflow and saturation**: with the buffer full and the host stalled, hold `noc_wr_en`=1 for 300 cycles → `drop_count` stops at 255; the buffered contents are unchanged.
- **Wrap-around and simultaneous push/pop**: stream 20 words 0x10..0x23 with a host model that acks after 1 cycle → all 20 words delivered in order. `level` is unchanged on cycles where a push and the IDLE pop coincide.
- **Enable freeze and mid-operation reset**:
  - Drop `ena` while in REQ and pulse `host_ack`: `host_req` stays 1 and `noc_wr_en` writes are ignored (`level` unchanged, `drop_count` unchanged).
  - Then restore `ena` and assert `rst_n`=0 for 1 cycle mid-REQ: `host_req`=0 and `level`=0 on the next cycle.

Source files
------------

// File: rtl/noc_egress_port.sv
// Egress end of the NoC ring: buffers words written by the last switch and
// hands them to the host one at a time over a 4-phase req/ack handshake.
module noc_egress_port #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [DATA_WIDTH-1:0]  noc_data_in,
  input  logic                   noc_wr_en,
  output logic                   noc_full,
  input  logic                   host_ack,
  output logic [DATA_WIDTH-1:0]  host_data,
  output logic                   host_req,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             drop_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RELEASE = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]        level_q, level_d;
  logic [7:0]            drop_q, drop_d;
  logic                  host_req_q, host_req_d;
  logic [DATA_WIDTH-1:0] host_data_q, host_data_d;
  logic                  ack_meta_q, ack_s_q;
  logic                  full;
  logic                  push;
  logic                  pop;

  assign full = (level_q == FULL_LVL);

  always_comb begin
    state_d     = state_q;
    host_req_d  = host_req_q;
    host_data_d = host_data_q;
    drop_d      = drop_q;
    pop         = 1'b0;
    // A full buffer refuses the incoming word even if the IDLE pop frees a slot.
    push        = ena & noc_wr_en & ~full;
    if (ena && noc_wr_en && full && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (level_q != '0) begin
            pop         = 1'b1;
            host_data_d = mem_q[rd_ptr_q];
            host_req_d  = 1'b1;
            state_d     = REQ;
          end
        end
        REQ: begin
          if (ack_s_q) begin
            host_req_d = 1'b0;
            state_d    = RELEASE;
          end
        end
        RELEASE: begin
          if (!ack_s_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    wr_ptr_d = push ? wr_ptr_q + (PTR_W)'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + (PTR_W)'(1) : rd_ptr_q;
    level_d  = level_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      drop_q      <= '0;
      host_req_q  <= 1'b0;
      host_data_q <= '0;
      ack_meta_q  <= 1'b0;
      ack_s_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      drop_q      <= drop_d;
      host_req_q  <= host_req_d;
      host_data_q <= host_data_d;
      // The ack synchronizer keeps running while the block is disabled.
      ack_meta_q  <= host_ack;
      ack_s_q     <= ack_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= noc_data_in;
  end

  assign noc_full   = full;
  assign host_data  = host_data_q;
  assign host_req   = host_req_q;
  assign level      = level_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_noc_egress_port.sv
// Bench for noc_egress_port: vector table, directed corner sequences and a
// randomized run against a queue-based reference model of the egress port.
module tb_noc_egress_port;
  localparam int DEPTH = 4;
  localparam int DW    = 8;

  logic       clk = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       ena_i = 1'b1;
  logic       wr_i = 1'b0;
  logic       ack_i = 1'b0;
  logic [7:0] din_i = 8'h00;
  logic       noc_full;
  logic       host_req;
  logic [7:0] host_data;
  logic [7:0] drop_count;
  logic [2:0] level;

  noc_egress_port #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n_i),
    .ena        (ena_i),
    .noc_data_in(din_i),
    .noc_wr_en  (wr_i),
    .noc_full   (noc_full),
    .host_ack   (ack_i),
    .host_data  (host_data),
    .host_req   (host_req),
    .level      (level),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a word queue plus the handshake phase and ack history.
  logic [7:0] mq[$];
  logic       m_req  = 1'b0;
  logic [7:0] m_data = 8'h00;
  int         m_drop = 0;
  int         m_phase = 0;   // 0 waiting for a word, 1 waiting for ack, 2 waiting for ack release
  logic       m_a1 = 1'b0;
  logic       m_a2 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic acks;
    bit   was_full;
    if (!rst_n_i) begin
      mq.delete();
      m_req = 1'b0; m_data = 8'h00; m_drop = 0; m_phase = 0;
      m_a1 = 1'b0; m_a2 = 1'b0;
      return;
    end
    acks = m_a2;
    m_a2 = m_a1;
    m_a1 = ack_i;
    if (!ena_i) return;
    was_full = (mq.size() == DEPTH);
    case (m_phase)
      0: if (mq.size() > 0) begin m_data = mq.pop_front(); m_req = 1'b1; m_phase = 1; end
      1: if (acks) begin m_req = 1'b0; m_phase = 2; end
      default: if (!acks) m_phase = 0;
    endcase
    if (wr_i) begin
      if (was_full) begin
        if (m_drop < 255) m_drop++;
      end else begin
        mq.push_back(din_i);
      end
    end
  endtask

  task automatic compare_all();
    check("host_req",   host_req,   m_req);
    check("host_data",  host_data,  m_data);
    check("level",      level,      mq.size());
    check("noc_full",   noc_full,   (mq.size() == DEPTH));
    check("drop_count", drop_count, m_drop);
  endtask

  // One clock: model steps with the DUT on the rising edge, outputs compared on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  task automatic host_xfer(output logic [7:0] w);
    int n;
    n = 0;
    while (host_req !== 1'b1 && n < 64) begin cycle(); n++; end
    check("xfer_req_seen", host_req, 1'b1);
    w = host_data;
    ack_i = 1'b1;
    n = 0;
    while (host_req !== 1'b0 && n < 64) begin cycle(); n++; end
    check("xfer_req_drop", host_req, 1'b0);
    ack_i = 1'b0;
  endtask

  typedef struct {
    logic       rst_n, ena, wr;
    logic [7:0] din;
    logic       ack;
    logic       req;
    logic [7:0] data;
    logic [2:0] lvl;
    logic       full;
    logic [7:0] drop;
  } vec_t;

  vec_t tbl[21];

  initial begin
    logic [7:0] w;
    logic [7:0] first5[5];
    logic [7:0] rx[$];

    //            rst   ena   wr    din    ack  | req   data   lvl   full  drop
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0, 8'd0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 3'd0, 1'b0, 8'd0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 3'd0, 1'b0, 8'd0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 3'd0, 1'b0, 8'd0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 3'd0, 1'b0, 8'd0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 3'd0, 1'b0, 8'd0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 3'd0, 1'b0, 8'd0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 3'd0, 1'b0, 8'd0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b0, 8'd0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b0, 8'd0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 3'd0, 1'b0, 8'd0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 8'hA5, 3'd1, 1'b0, 8'd0};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 3'd0, 1'b0, 8'd0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, 3'd0, 1'b0, 8'd0};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'h5A, 3'd0, 1'b0, 8'd0};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h5A, 3'd0, 1'b0, 8'd0};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 3'd0, 1'b0, 8'd0};
    tbl[19] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 3'd0, 1'b0, 8'd0};
    tbl[20] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 3'd0, 1'b0, 8'd0};

    // Reset values, single-word latency and the full handshake timing.
    for (int i = 0; i < 21; i++) begin
      rst_n_i = tbl[i].rst_n; ena_i = tbl[i].ena; wr_i = tbl[i].wr;
      din_i   = tbl[i].din;   ack_i = tbl[i].ack;
      cycle();
      check($sformatf("tbl%0d_req",  i), host_req,   tbl[i].req);
      check($sformatf("tbl%0d_data", i), host_data,  tbl[i].data);
      check($sformatf("tbl%0d_lvl",  i), level,      tbl[i].lvl);
      check($sformatf("tbl%0d_full", i), noc_full,   tbl[i].full);
      check($sformatf("tbl%0d_drop", i), drop_count, tbl[i].drop);
    end

    // Burst ordering with a stalled host.
    ack_i = 1'b0; wr_i = 1'b1;
    for (int i = 1; i <= 5; i++) begin din_i = 8'(i); cycle(); end
    wr_i = 1'b0;
    check("burst_head",  host_data, 8'h01);
    check("burst_level", level, 3'd4);
    check("burst_full",  noc_full, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      host_xfer(w);
      check($sformatf("burst_word%0d", i), w, i);
    end
    check("burst_drop", drop_count, 8'd0);
    for (int i = 0; i < 4; i++) cycle();

    // Overflow with drop-counter saturation.
    wr_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      din_i = 8'($urandom);
      if (i < 5) first5[i] = din_i;
      cycle();
    end
    wr_i = 1'b0;
    check("ovf_drop_sat", drop_count, 8'd255);
    check("ovf_level",    level, 3'd4);
    for (int i = 0; i < 5; i++) begin
      host_xfer(w);
      check($sformatf("ovf_word%0d", i), w, first5[i]);
    end
    for (int i = 0; i < 4; i++) cycle();

    // Streaming with wrap-around and a host that acks one cycle after req.
    begin
      int   sent, n, hold;
      logic prev_req;
      sent = 0; n = 0; hold = 0; prev_req = 1'b0;
      while (rx.size() < 20 && n < 2000) begin
        if (host_req && !prev_req) rx.push_back(host_data);
        prev_req = host_req;
        if (host_req && !ack_i) begin
          if (hold >= 1) ack_i = 1'b1; else hold++;
        end else if (!host_req) begin
          ack_i = 1'b0; hold = 0;
        end
        if (sent < 20 && !noc_full) begin
          wr_i = 1'b1; din_i = 8'(8'h10 + sent); sent++;
        end else begin
          wr_i = 1'b0;
        end
        cycle();
        n++;
      end
      wr_i = 1'b0; ack_i = 1'b0;
      check("stream_count", rx.size(), 20);
      for (int i = 0; i < rx.size() && i < 20; i++)
        check($sformatf("stream_word%0d", i), rx[i], 8'(8'h10 + i));
      for (int i = 0; i < 6; i++) cycle();
    end

    // Randomized traffic against the reference model, including resets and enable drops.
    for (int i = 0; i < 1500; i++) begin
      rst_n_i = ($urandom_range(0, 199) != 0);
      ena_i   = ($urandom_range(0, 9) != 0);
      wr_i    = ($urandom_range(0, 9) < 6);
      din_i   = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ack_i = ~ack_i;
      cycle();
    end
    rst_n_i = 1'b1; ena_i = 1'b1; wr_i = 1'b0; ack_i = 1'b0;

    // Enable freeze mid-REQ, then reset mid-REQ.
    rst_n_i = 1'b0; cycle();
    rst_n_i = 1'b1;
    wr_i = 1'b1; din_i = 8'hC1; cycle();
    din_i = 8'hC2; cycle();
    wr_i = 1'b0;
    check("frz_req_before",  host_req, 1'b1);
    check("frz_data_before", host_data, 8'hC1);
    check("frz_lvl_before",  level, 3'd1);
    ena_i = 1'b0; wr_i = 1'b1; din_i = 8'hEE;
    for (int i = 0; i < 7; i++) begin
      ack_i = (i < 3);
      cycle();
      check($sformatf("frz_req%0d", i), host_req, 1'b1);
    end
    check("frz_level", level, 3'd1);
    check("frz_drop",  drop_count, 8'd0);
    check("frz_data",  host_data, 8'hC1);
    wr_i = 1'b0; ack_i = 1'b0; ena_i = 1'b1; rst_n_i = 1'b0;
    cycle();
    check("rst_mid_req",   host_req, 1'b0);
    check("rst_mid_level", level, 3'd0);
    check("rst_mid_data",  host_data, 8'h00);
    rst_n_i = 1'b1;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
